morty_mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the execute stage; consumes the EX/MEM pipeline register contents.
- Performs aligned loads and stores on a Wishbone-style data port and sign/zero-extends load data.
- Flags misaligned accesses and bus errors as exceptions.
- Contains the MEM/WB pipeline register; requests a pipeline stall while a bus access is outstanding.

---
 rtl/morty_mem_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_morty_mem_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morty_mem_stage.sv
// morty_mem_stage: memory-access stage. It issues aligned Wishbone loads/stores, extends load data and holds the MEM/WB register.
// Latency: non-bus and trapped ops reach MEM/WB one cycle after entry; a bus op takes 1 request cycle, then BUS cycles up to ack/err, then DONE.
// Backpressure: mem_stall_req_o holds upstream during a bus access; wb_stall_i holds MEM/WB and keeps a finished access parked in DONE.
//
// Ports:
//   clk_i, rst_i (synchronous, active high)
//   wb_stall_i / wb_bubble_i       : MEM/WB hold / bubble insert (bubble wins)
//   mem_*_i                        : EX/MEM register contents (pc, result/address, store data, rd, flags, exception)
//   dport_*                        : Wishbone-style data port (word address, lane select, replicated store data)
//   mem_stall_req_o, mem_fwd_dat_o : stall request upstream, forwarding value
//   wb_*_o                         : MEM/WB register outputs
// Build option: define MORTY_MEM_TIMEOUT_EN to add a BUS watchdog of TIMEOUT_CYCLES cycles (err path on expiry).
module morty_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_stall_i,
    input  logic        wb_bubble_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_store_data_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [5:0]  mem_mem_flags_i,
    input  logic        mem_mem_ex_sel_i,
    input  logic [3:0]  mem_exception_i,
    input  logic [31:0] mem_exc_data_i,
    input  logic        mem_trap_valid_i,
    output logic [31:0] dport_address_o,
    output logic [31:0] dport_dat_o,
    output logic [3:0]  dport_sel_o,
    output logic        dport_cyc_o,
    output logic        dport_stb_o,
    output logic        dport_we_o,
    input  logic [31:0] dport_dat_i,
    input  logic        dport_ack_i,
    input  logic        dport_err_i,
    output logic        mem_stall_req_o,
    output logic [31:0] mem_fwd_dat_o,
    output logic [31:0] wb_pc_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic [31:0] wb_wdata_o,
    output logic [3:0]  wb_exception_o,
    output logic [31:0] wb_exc_data_o,
    output logic        wb_trap_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Instruction decode
    logic is_load, is_store, is_byte, is_half, is_word, is_unsigned;
    logic mem_op, misaligned, access_req;

    assign is_load     = mem_mem_flags_i[0];
    assign is_store    = mem_mem_flags_i[1];
    assign is_byte     = mem_mem_flags_i[2];
    assign is_half     = mem_mem_flags_i[3];
    assign is_word     = mem_mem_flags_i[4];
    assign is_unsigned = mem_mem_flags_i[5];

    assign mem_op     = is_load | is_store;
    assign misaligned = (is_half & mem_result_i[0]) | (is_word & (|mem_result_i[1:0]));
    assign access_req = mem_op & ~mem_trap_valid_i & ~misaligned;

    // Lane select and store-data replication from the live inputs
    logic [3:0]  sel_in;
    logic [31:0] sdat_in;

    always_comb begin
        sel_in  = 4'b1111;
        sdat_in = mem_store_data_i;
        if (is_byte) begin
            sel_in  = 4'b0001 << mem_result_i[1:0];
            sdat_in = {4{mem_store_data_i[7:0]}};
        end else if (is_half) begin
            sel_in  = 4'b0011 << mem_result_i[1:0];
            sdat_in = {2{mem_store_data_i[15:0]}};
        end
    end

    // Access context captured on IDLE -> BUS so the bus sees stable values
    logic [31:0] addr_q;
    logic [31:0] sdat_q;
    logic [3:0]  sel_q;
    logic        store_q;
    logic [2:0]  size_q;     // {unsigned, half, byte}
    logic [31:0] rdata_q;
    logic        fault_q;

    logic in_bus;
    assign in_bus = (state_q == ST_BUS);

    // Watchdog
    logic timeout_hit;
`ifdef MORTY_MEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !in_bus) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Counter is 0 in the first BUS cycle, so this fires in BUS cycle TIMEOUT_CYCLES.
    assign timeout_hit = in_bus && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: BUS waits for ack/err indefinitely; the limit has no effect in this build.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    logic bus_fault;
    assign bus_fault = dport_err_i | timeout_hit;

    // Load data extraction from the captured address/size
    logic [31:0] rd_shift, rd_ext;

    always_comb begin
        rd_shift = dport_dat_i >> {addr_q[1:0], 3'b000};
        rd_ext   = rd_shift;
        if (size_q[0]) begin
            rd_ext = {{24{rd_shift[7] & ~size_q[2]}}, rd_shift[7:0]};
        end else if (size_q[1]) begin
            rd_ext = {{16{rd_shift[15] & ~size_q[2]}}, rd_shift[15:0]};
        end
    end

    // FSM next state / bus activity / stall
    logic bus_active;

    always_comb begin
        state_d         = state_q;
        bus_active      = 1'b0;
        mem_stall_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_req) begin
                    bus_active      = 1'b1;
                    mem_stall_req_o = 1'b1;
                    state_d         = ST_BUS;
                end
            end
            ST_BUS: begin
                bus_active      = 1'b1;
                mem_stall_req_o = 1'b1;
                if (dport_ack_i || bus_fault) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stay parked while WB is held so the access is not replayed
                // from the still-present EX/MEM contents.
                if (!wb_stall_i || wb_bubble_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sdat_q  <= '0;
            sel_q   <= '0;
            store_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && access_req) begin
                addr_q  <= mem_result_i;
                sdat_q  <= sdat_in;
                sel_q   <= sel_in;
                store_q <= is_store;
                size_q  <= {is_unsigned, is_half, is_byte};
            end
            if (in_bus && (dport_ack_i || bus_fault)) begin
                rdata_q <= rd_ext;
                fault_q <= bus_fault;   // err outranks a simultaneous ack
            end
        end
    end

    // Bus port: live inputs in the request cycle, captured values in BUS.
    // Reset gates the strobes so a pending cycle drops immediately.
    logic [31:0] addr_cur;
    assign addr_cur        = in_bus ? addr_q : mem_result_i;
    assign dport_address_o = {addr_cur[31:2], 2'b00};
    assign dport_dat_o     = in_bus ? sdat_q : sdat_in;
    assign dport_sel_o     = in_bus ? sel_q : sel_in;
    assign dport_cyc_o     = bus_active & ~rst_i;
    assign dport_stb_o     = bus_active & ~rst_i;
    assign dport_we_o      = bus_active & ~rst_i & (in_bus ? store_q : is_store);

    assign mem_fwd_dat_o = (state_q == ST_DONE && mem_mem_ex_sel_i) ? rdata_q : mem_result_i;

    // MEM/WB next values
    logic        wb_we_d, wb_trap_d;
    logic [31:0] wb_wdata_d, wb_exc_data_d;
    logic [3:0]  wb_exc_d;

    always_comb begin
        wb_we_d       = mem_we_i & ~is_store;
        wb_wdata_d    = mem_mem_ex_sel_i ? rdata_q : mem_result_i;
        wb_exc_d      = 4'd0;
        wb_exc_data_d = 32'd0;
        wb_trap_d     = 1'b0;
        if (mem_trap_valid_i) begin
            wb_exc_d      = mem_exception_i;
            wb_exc_data_d = mem_exc_data_i;
            wb_trap_d     = 1'b1;
            wb_we_d       = 1'b0;
        end else if (mem_op && misaligned) begin
            wb_exc_d      = is_store ? 4'd6 : 4'd4;
            wb_exc_data_d = mem_result_i;
            wb_trap_d     = 1'b1;
            wb_we_d       = 1'b0;
        end else if (state_q == ST_DONE && fault_q) begin
            wb_exc_d      = store_q ? 4'd7 : 4'd5;
            wb_exc_data_d = addr_q;
            wb_trap_d     = 1'b1;
            wb_we_d       = 1'b0;
        end
    end

    logic wb_load;
    assign wb_load = ~mem_stall_req_o & ~wb_stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_pc_o         <= '0;
            wb_waddr_o      <= '0;
            wb_we_o         <= 1'b0;
            wb_wdata_o      <= '0;
            wb_exception_o  <= '0;
            wb_exc_data_o   <= '0;
            wb_trap_valid_o <= 1'b0;
        end else if (wb_bubble_i) begin
            wb_we_o         <= 1'b0;
            wb_trap_valid_o <= 1'b0;
            wb_exception_o  <= '0;
        end else if (wb_load) begin
            wb_pc_o         <= mem_pc_i;
            wb_waddr_o      <= mem_waddr_i;
            wb_we_o         <= wb_we_d;
            wb_wdata_o      <= wb_wdata_d;
            wb_exception_o  <= wb_exc_d;
            wb_exc_data_o   <= wb_exc_data_d;
            wb_trap_valid_o <= wb_trap_d;
        end
    end

endmodule

// File: tb/tb_morty_mem_stage.sv
// tb_morty_mem_stage: directed plus randomized checks of morty_mem_stage against a behavioural model.
// Latency: drives one operation at a time, waiting for the stage to finish each one.
// Backpressure: exercises wb_stall_i hold and wb_bubble_i insertion explicitly.
module tb_morty_mem_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_stall_i, wb_bubble_i;
    logic [31:0] mem_pc_i, mem_result_i, mem_store_data_i;
    logic [4:0]  mem_waddr_i;
    logic        mem_we_i;
    logic [5:0]  mem_mem_flags_i;
    logic        mem_mem_ex_sel_i;
    logic [3:0]  mem_exception_i;
    logic [31:0] mem_exc_data_i;
    logic        mem_trap_valid_i;
    logic [31:0] dport_address_o, dport_dat_o, dport_dat_i;
    logic [3:0]  dport_sel_o;
    logic        dport_cyc_o, dport_stb_o, dport_we_o, dport_ack_i, dport_err_i;
    logic        mem_stall_req_o;
    logic [31:0] mem_fwd_dat_o, wb_pc_o, wb_wdata_o, wb_exc_data_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o, wb_trap_valid_o;
    logic [3:0]  wb_exception_o;

    always #5 clk = ~clk;

    morty_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .wb_stall_i(wb_stall_i), .wb_bubble_i(wb_bubble_i),
        .mem_pc_i(mem_pc_i), .mem_result_i(mem_result_i), .mem_store_data_i(mem_store_data_i),
        .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i), .mem_mem_flags_i(mem_mem_flags_i),
        .mem_mem_ex_sel_i(mem_mem_ex_sel_i), .mem_exception_i(mem_exception_i),
        .mem_exc_data_i(mem_exc_data_i), .mem_trap_valid_i(mem_trap_valid_i),
        .dport_address_o(dport_address_o), .dport_dat_o(dport_dat_o), .dport_sel_o(dport_sel_o),
        .dport_cyc_o(dport_cyc_o), .dport_stb_o(dport_stb_o), .dport_we_o(dport_we_o),
        .dport_dat_i(dport_dat_i), .dport_ack_i(dport_ack_i), .dport_err_i(dport_err_i),
        .mem_stall_req_o(mem_stall_req_o), .mem_fwd_dat_o(mem_fwd_dat_o),
        .wb_pc_o(wb_pc_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .wb_wdata_o(wb_wdata_o),
        .wb_exception_o(wb_exception_o), .wb_exc_data_o(wb_exc_data_o),
        .wb_trap_valid_o(wb_trap_valid_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        bus;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic [31:0] bdat;
        logic        bwe;
        logic [31:0] ld_val;
        logic        wb_we;
        logic [31:0] wdata;
        logic [3:0]  exc;
        logic [31:0] excd;
        logic        trap;
    } exp_t;

    // Reference: what the stage must do with one instruction, from the rules directly.
    function automatic exp_t model(input logic ld, input logic st, input int size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] sdata,
                                   input logic we, input logic exsel, input logic [31:0] rdata,
                                   input logic trap_in, input logic [3:0] exc_in,
                                   input logic [31:0] excd_in, input logic bus_fault);
        exp_t   e;
        int     off;
        longint v, span;
        logic   misal;
        off     = int'(addr % 32'd4);
        e.bus   = 1'b0;
        e.baddr = addr - 32'(off);
        e.sel   = 4'(((1 << size) - 1) << off);
        if (size == 1)      e.bdat = (sdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.bdat = (sdata & 32'hFFFF) * 32'h0001_0001;
        else                e.bdat = sdata;
        e.bwe = st;
        v = longint'(rdata >> (8 * off));
        if (size < 4) begin
            span = longint'(1) << (8 * size);
            v = v % span;
            if (!uns && v >= span / 2) v = v - span;
        end
        e.ld_val = 32'(v);
        misal   = (ld || st) && ((addr % 32'(size)) != 0);
        e.wb_we = we && !st;
        e.wdata = exsel ? e.ld_val : addr;
        e.trap  = 1'b0;
        e.exc   = 4'd0;
        e.excd  = 32'd0;
        if (trap_in) begin
            e.trap = 1'b1; e.exc = exc_in; e.excd = excd_in; e.wb_we = 1'b0;
        end else if (misal) begin
            e.trap = 1'b1; e.exc = st ? 4'd6 : 4'd4; e.excd = addr; e.wb_we = 1'b0;
        end else if (ld || st) begin
            e.bus = 1'b1;
            if (bus_fault) begin
                e.trap = 1'b1; e.exc = st ? 4'd7 : 4'd5; e.excd = addr; e.wb_we = 1'b0;
            end
        end
        return e;
    endfunction

    logic [31:0] last_bdat;
    logic [3:0]  last_sel;
    logic        last_bwe;

    task automatic drive_nop();
        mem_pc_i = '0; mem_result_i = '0; mem_store_data_i = '0; mem_waddr_i = '0;
        mem_we_i = 1'b0; mem_mem_flags_i = '0; mem_mem_ex_sel_i = 1'b0;
        mem_exception_i = '0; mem_exc_data_i = '0; mem_trap_valid_i = 1'b0;
        dport_ack_i = 1'b0; dport_err_i = 1'b0;
    endtask

    // One instruction through the stage. ack_dly = BUS cycle (1-based) in which the slave
    // answers; 0 means never. tmo says the watchdog is expected to end the access.
    task automatic run_op(input logic ld, input logic st, input int size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic we,
                          input logic exsel, input logic [31:0] rdata, input logic trap_in,
                          input int ack_dly, input logic use_err, input logic tmo);
        exp_t        e;
        logic [31:0] pc, excd_in;
        logic [4:0]  wa;
        logic [3:0]  exc_in;
        logic        both, fin, stable;
        int          stalls, exp_stalls;
        pc = $urandom; wa = 5'($urandom); exc_in = 4'($urandom); excd_in = $urandom;
        both = 1'($urandom_range(0, 1));
        e = model(ld, st, size, uns, addr, sdata, we, exsel, rdata, trap_in, exc_in, excd_in,
                  use_err || tmo);
        @(negedge clk);
        mem_pc_i = pc; mem_result_i = addr; mem_store_data_i = sdata; mem_waddr_i = wa;
        mem_we_i = we; mem_mem_ex_sel_i = exsel;
        mem_mem_flags_i = {uns, size == 4, size == 2, size == 1, st, ld};
        mem_exception_i = exc_in; mem_exc_data_i = excd_in; mem_trap_valid_i = trap_in;
        dport_dat_i = rdata; dport_ack_i = 1'b0; dport_err_i = 1'b0;
        #1;
        check("req_cyc", 32'(dport_cyc_o), 32'(e.bus));
        check("req_stall", 32'(mem_stall_req_o), 32'(e.bus));
        if (e.bus) begin
            check("req_sel", 32'(dport_sel_o), 32'(e.sel));
            check("req_addr", dport_address_o, e.baddr);
            check("req_we", 32'(dport_we_o), 32'(e.bwe));
            if (st) check("req_dat", dport_dat_o, e.bdat);
        end
        last_bdat = dport_dat_o; last_sel = dport_sel_o; last_bwe = dport_we_o;
        stalls = mem_stall_req_o ? 1 : 0;
        fin    = !mem_stall_req_o;
        stable = 1'b1;
        for (int c = 1; c < 200 && !fin; c++) begin
            @(negedge clk);
            dport_err_i = use_err && (c == ack_dly);
            dport_ack_i = (c == ack_dly) && (!use_err || both);
            #1;
            if (mem_stall_req_o) begin
                stalls++;
                if (dport_cyc_o !== 1'b1 || dport_stb_o !== 1'b1 || dport_address_o !== e.baddr ||
                    dport_sel_o !== e.sel || dport_we_o !== e.bwe) stable = 1'b0;
            end else begin
                fin = 1'b1;
                check("done_cyc", 32'(dport_cyc_o), 32'd0);
                if (ld && exsel && !e.trap) check("done_fwd", mem_fwd_dat_o, e.ld_val);
            end
        end
        exp_stalls = !e.bus ? 0 : (tmo ? 1 + TMO : 1 + ack_dly);
        check("finished", 32'(fin), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (e.bus) check("bus_stable", 32'(stable), 32'd1);
        @(negedge clk);
        drive_nop();
        #1;
        check("wb_pc", wb_pc_o, pc);
        check("wb_waddr", 32'(wb_waddr_o), 32'(wa));
        check("wb_we", 32'(wb_we_o), 32'(e.wb_we));
        check("wb_trap", 32'(wb_trap_valid_o), 32'(e.trap));
        if (e.trap) begin
            check("wb_exc", 32'(wb_exception_o), 32'(e.exc));
            check("wb_excd", wb_exc_data_o, e.excd);
        end else begin
            check("wb_wdata", wb_wdata_o, e.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic       r_ld, r_st, r_uns, r_we, r_trap, r_err;
        int         r_sz, r_kind;
        logic [31:0] r_addr;

        rst_i = 1'b1; wb_stall_i = 1'b0; wb_bubble_i = 1'b0; dport_dat_i = '0;
        drive_nop();
        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_pc", wb_pc_o, 32'd0);
        check("rst_wb_waddr", 32'(wb_waddr_o), 32'd0);
        check("rst_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_wb_wdata", wb_wdata_o, 32'd0);
        check("rst_wb_exc", 32'(wb_exception_o), 32'd0);
        check("rst_wb_excd", wb_exc_data_o, 32'd0);
        check("rst_wb_trap", 32'(wb_trap_valid_o), 32'd0);
        check("rst_cyc", 32'({dport_cyc_o, dport_stb_o, dport_we_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // LW 0x100, ack in the 2nd BUS cycle: 3 stall cycles
        run_op(1, 0, 4, 0, 32'h100, 32'h0, 1, 1, 32'hDEAD_BEEF, 0, 2, 0, 0);
        check("lw_wdata", wb_wdata_o, 32'hDEAD_BEEF);
        check("lw_sel", 32'(last_sel), 32'hF);
        // LB / LBU at 0x103
        run_op(1, 0, 1, 0, 32'h103, 32'h0, 1, 1, 32'h8012_3456, 0, 1, 0, 0);
        check("lb_wdata", wb_wdata_o, 32'hFFFF_FF80);
        check("lb_sel", 32'(last_sel), 32'b1000);
        run_op(1, 0, 1, 1, 32'h103, 32'h0, 1, 1, 32'h8012_3456, 0, 3, 0, 0);
        check("lbu_wdata", wb_wdata_o, 32'h0000_0080);
        // SH at 0x202
        run_op(0, 1, 2, 0, 32'h202, 32'h1234_ABCD, 1, 0, 32'h0, 0, 1, 0, 0);
        check("sh_dat", last_bdat, 32'hABCD_ABCD);
        check("sh_sel", 32'(last_sel), 32'b1100);
        check("sh_we", 32'(last_bwe), 32'd1);
        check("sh_wb_we", 32'(wb_we_o), 32'd0);
        // Misaligned LW
        run_op(1, 0, 4, 0, 32'h101, 32'h0, 1, 1, 32'h0, 0, 1, 0, 0);
        check("mis_exc", 32'(wb_exception_o), 32'd4);
        check("mis_excd", wb_exc_data_o, 32'h101);
        // SW with err in the first BUS cycle
        run_op(0, 1, 4, 0, 32'h300, 32'h5A5A_5A5A, 0, 0, 32'h0, 0, 1, 1, 0);
        check("sw_err_exc", 32'(wb_exception_o), 32'd7);
`ifdef MORTY_MEM_TIMEOUT_EN
        run_op(0, 1, 4, 0, 32'h304, 32'h1, 0, 0, 32'h0, 0, 0, 0, 1);
        check("tmo_exc", 32'(wb_exception_o), 32'd7);
`else
        run_op(0, 1, 4, 0, 32'h304, 32'h1, 0, 0, 32'h0, 0, 40, 0, 0);
        check("long_wait_trap", 32'(wb_trap_valid_o), 32'd0);
`endif

        // WB hold during DONE, then bubble while stalled
        @(negedge clk);
        mem_pc_i = 32'hAAAA_0000; mem_result_i = 32'h5555; mem_we_i = 1'b1; mem_waddr_i = 5'd7;
        @(negedge clk);
        wb_stall_i = 1'b1;
        mem_pc_i = 32'h0000_0440; mem_result_i = 32'h40; mem_mem_flags_i = 6'b010001;
        mem_mem_ex_sel_i = 1'b1; dport_dat_i = 32'h1357_9BDF;
        @(negedge clk); dport_ack_i = 1'b1;
        @(negedge clk); dport_ack_i = 1'b0;
        #1;
        check("hold_done_stall", 32'(mem_stall_req_o), 32'd0);
        @(negedge clk);
        #1;
        check("hold_pc", wb_pc_o, 32'hAAAA_0000);
        check("hold_wdata", wb_wdata_o, 32'h5555);
        check("hold_we", 32'(wb_we_o), 32'd1);
        wb_bubble_i = 1'b1;
        @(negedge clk);
        wb_bubble_i = 1'b0; wb_stall_i = 1'b0;
        drive_nop();
        #1;
        check("bubble_we", 32'(wb_we_o), 32'd0);
        check("bubble_trap", 32'(wb_trap_valid_o), 32'd0);
        check("bubble_pc", wb_pc_o, 32'hAAAA_0000);

        // Reset during BUS: cycle drops at once; a late ack is ignored
        @(negedge clk);
        mem_pc_i = 32'h880; mem_result_i = 32'h80; mem_mem_flags_i = 6'b010001;
        mem_we_i = 1'b1; mem_mem_ex_sel_i = 1'b1; dport_dat_i = 32'h2468_ACE0;
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("rst_bus_cyc", 32'(dport_cyc_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        drive_nop();
        dport_ack_i = 1'b1;
        #1;
        check("rst_late_cyc", 32'(dport_cyc_o), 32'd0);
        check("rst_late_stall", 32'(mem_stall_req_o), 32'd0);
        @(negedge clk);
        dport_ack_i = 1'b0;
        #1;
        check("rst_late_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_late_wb_wdata", wb_wdata_o, 32'd0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            r_kind = $urandom_range(0, 2);
            r_ld   = (r_kind == 0);
            r_st   = (r_kind == 1);
            r_sz   = 1 << $urandom_range(0, 2);
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(r_sz - 1);
            r_uns  = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_trap = ($urandom_range(0, 7) == 0);
            r_err  = ($urandom_range(0, 5) == 0);
            run_op(r_ld, r_st, r_sz, r_uns, r_addr, $urandom, r_we, r_ld, $urandom, r_trap,
                   $urandom_range(1, 4), r_err, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
